div: RTL and testbench

Multi-cycle 32-bit integer divider serving the EX stage of the OpenMIPS pipeline for DIV/DIVU. EX drives operands, signedness and a start level. This block runs a radix-2 restoring division, one quotient bit per cycle. It returns {remainder, quotient} with a ready flag, which EX writes into HI/LO. `annul_i` aborts an operation in flight, for example on a pipeline flush.

---
 rtl/div_if.sv | 31 +++
 rtl/div.sv | 158 +++++++++++++++
 tb/tb_div.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Purpose : EX-stage <-> divider handshake bundle for DIV/DIVU.
// Signals : signed_div_i  - 1 = signed (DIV), 0 = unsigned (DIVU)
//           opdata1_i     - dividend
//           opdata2_i     - divisor
//           start_i       - level request, held until ready_o is seen
//           annul_i       - abort the current or requested operation
//           result_o      - {remainder, quotient}
//           ready_o       - result valid
// Modports: master = EX stage, slave = divider.
interface div_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;

  logic              signed_div_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [RES_W-1:0]  result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Purpose : multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
//           One quotient bit per cycle; result {remainder, quotient}.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-low reset
//           bus  - div_if.slave (operands, start/annul, result/ready)
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned DVD_W  = 65;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(32);

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_BYZERO = 2'b01,
    ST_ON     = 2'b10,
    ST_END    = 2'b11
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DVD_W-1:0]  r_dividend, w_dividend_nxt;
  logic [DATA_W-1:0] r_divisor, w_divisor_nxt;
  logic              r_sign1, w_sign1_nxt;
  logic              r_sign2, w_sign2_nxt;
  logic              r_signed_q, w_signed_q_nxt;
  logic [RES_W-1:0]  r_result, w_result_nxt;
  logic              r_ready, w_ready_nxt;

  logic              w_req;
  logic              w_div_zero;
  logic [DATA_W-1:0] w_op1_abs;
  logic [DATA_W-1:0] w_op2_abs;
  logic [DATA_W:0]   w_temp;
  logic [DATA_W-1:0] w_quot_fix;
  logic [DATA_W-1:0] w_rem_fix;

  assign w_req      = bus.start_i && !bus.annul_i;
  assign w_div_zero = (bus.opdata2_i == '0);

  // Magnitudes: negate only signed negatives; 0x80000000 maps to itself.
  assign w_op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ?
                     (~bus.opdata1_i) + DATA_W'(1) : bus.opdata1_i;
  assign w_op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ?
                     (~bus.opdata2_i) + DATA_W'(1) : bus.opdata2_i;

  // Trial subtraction of the divisor from the current partial remainder.
  assign w_temp = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

  // Sign correction: quotient negative when signs differ, remainder follows dividend.
  assign w_quot_fix = (r_signed_q && (r_sign1 != r_sign2)) ?
                      (~r_dividend[31:0]) + DATA_W'(1) : r_dividend[31:0];
  assign w_rem_fix  = (r_signed_q && r_sign1) ?
                      (~r_dividend[64:33]) + DATA_W'(1) : r_dividend[64:33];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_FREE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FREE:   if (w_req) w_state_nxt = w_div_zero ? ST_BYZERO : ST_ON;
      ST_BYZERO: w_state_nxt = ST_END;
      ST_ON: begin
        if (bus.annul_i)            w_state_nxt = ST_FREE;
        else if (r_cnt == CNT_LAST) w_state_nxt = ST_END;
      end
      ST_END:    if (!bus.start_i) w_state_nxt = ST_FREE;
      default:   w_state_nxt = ST_FREE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_sign1_nxt    = r_sign1;
    w_sign2_nxt    = r_sign2;
    w_signed_q_nxt = r_signed_q;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;
    case (r_state)
      ST_FREE: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
        if (w_req && !w_div_zero) begin
          w_cnt_nxt      = '0;
          w_dividend_nxt = {32'd0, w_op1_abs, 1'b0};
          w_divisor_nxt  = w_op2_abs;
          w_sign1_nxt    = bus.opdata1_i[DATA_W-1];
          w_sign2_nxt    = bus.opdata2_i[DATA_W-1];
          w_signed_q_nxt = bus.signed_div_i;
        end
      end
      ST_BYZERO: w_dividend_nxt = '0;
      ST_ON: begin
        if (!bus.annul_i) begin
          if (r_cnt != CNT_LAST) begin
            // Borrow means the divisor did not fit: shift in a 0 bit.
            if (w_temp[DATA_W]) w_dividend_nxt = {r_dividend[63:0], 1'b0};
            else                w_dividend_nxt = {w_temp[31:0], r_dividend[31:0], 1'b1};
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_dividend_nxt = {w_rem_fix, r_dividend[32], w_quot_fix};
          end
        end
      end
      ST_END: begin
        if (bus.start_i) begin
          w_ready_nxt  = 1'b1;
          w_result_nxt = {r_dividend[64:33], r_dividend[31:0]};
        end else begin
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end
      end
      default: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_signed_q <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_sign1    <= w_sign1_nxt;
      r_sign2    <= w_sign2_nxt;
      r_signed_q <= w_signed_q_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
endmodule

// File: tb/tb_div.sv
// Purpose : self-checking bench for div (directed cases, annul, reset, random ops
//           against an arithmetic reference model).
module tb_div;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_if u_if();

  div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one request; check latency and result; optionally hold, then release start.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input logic [63:0] exp, input bit release_start);
    int lat;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    u_if.opdata1_i    = a;
    u_if.opdata2_i    = b;
    u_if.signed_div_i = s;
    u_if.annul_i      = 1'b0;
    u_if.start_i      = 1'b1;
    lat = -1;
    for (int e = 0; e < 64; e++) begin
      @(posedge clk); #1;
      if (u_if.ready_o === 1'b1) begin
        lat = e;
        break;
      end
      // Operands are only sampled at edge 0; scramble them afterwards.
      if (e == 0) begin
        u_if.opdata1_i    = $urandom;
        u_if.opdata2_i    = $urandom;
        u_if.signed_div_i = ~s;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, u_if.result_o, exp);
    if (release_start) begin
      repeat (2) begin
        @(posedge clk); #1;
        check({tag, "_hold"}, {u_if.result_o}, exp);
      end
      check({tag, "_hold_ready"}, 64'(u_if.ready_o), 64'd1);
      @(negedge clk);
      u_if.start_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_drop_ready"}, 64'(u_if.ready_o), 64'd0);
      check({tag, "_drop_result"}, u_if.result_o, 64'd0);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    bit s;
    checks = 0;
    errors = 0;
    rst               = 1'b0;
    u_if.signed_div_i = 1'b0;
    u_if.opdata1_i    = '0;
    u_if.opdata2_i    = '0;
    u_if.start_i      = 1'b0;
    u_if.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(u_if.ready_o), 64'd0);
    check("reset_result", u_if.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_op("u_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b1);
    run_op("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
    run_op("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 1'b1);
    run_op("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b1);
    run_op("u_min_max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 1'b1);
    run_op("div_zero", 32'd5, 32'd0, 1'b0, 64'd0, 1'b1);

    // Annul at edge 10 with start still high: FSM returns to FREE and re-accepts at edge 11.
    @(negedge clk);
    u_if.opdata1_i    = 32'hFFFFFFFF;
    u_if.opdata2_i    = 32'd1;
    u_if.signed_div_i = 1'b0;
    u_if.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    u_if.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.annul_i = 1'b0;
    lat = -1;
    for (int e = 11; e < 90; e++) begin
      @(posedge clk); #1;
      if (u_if.ready_o === 1'b1) begin
        lat = e;
        break;
      end
    end
    check("annul_reissue_latency", 64'(lat), 64'd45);
    check("annul_reissue_result", u_if.result_o, 64'h00000000_FFFFFFFF);
    @(negedge clk);
    u_if.start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_drop_ready", 64'(u_if.ready_o), 64'd0);

    // Annul held in FREE blocks acceptance.
    @(negedge clk);
    u_if.opdata1_i = 32'd100;
    u_if.opdata2_i = 32'd7;
    u_if.start_i   = 1'b1;
    u_if.annul_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("free_annul_ready", 64'(u_if.ready_o), 64'd0);
    run_op("after_free_annul", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b1);

    // Reset mid-ON at edge 20.
    @(negedge clk);
    u_if.opdata1_i    = 32'd100;
    u_if.opdata2_i    = 32'd7;
    u_if.signed_div_i = 1'b0;
    u_if.start_i      = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_on_ready", 64'(u_if.ready_o), 64'd0);
    check("rst_on_result", u_if.result_o, 64'd0);
    u_if.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst_on", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b1);

    // Reset while a result is being shown: outputs clear without a clock edge.
    run_op("rst_end", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(u_if.ready_o), 64'd0);
    check("rst_end_result", u_if.result_o, 64'd0);
    u_if.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: a = 32'd0;
        default: ;
      endcase
      run_op("rand", a, b, s, ref_div(a, b, s), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
